alu_src_pipe: RTL and testbench

//  Registered ALU operand-select stage between decode and execute. Parametrised in data width.

---
 rtl/alu_src_pipe.sv | 149 ++++++++++++++
 tb/tb_alu_src_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_src_pipe.sv
// alu_src_pipe: registered ALU operand-select stage between decode and execute.
//  - Selects ALU src1/src2 from forwarded register values, immediate, PC or constant 4.
//  - Forwards results from EX and MEM (priority EX > MEM > regfile); x0 is never forwarded.
//  - Optional macro ALU_SRC_FWD_WB_EN adds WB forwarding at the lowest priority.
//    Without it the wb_* ports are present but ignored, and the regfile is assumed
//    to be write-before-read.
//  - Detects load-use hazards against the EX stage and refuses the op until EX advances.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
// A producer holding valid must keep its payload stable until ready is seen.
// Ready never depends on valid from the same side.
// Exception: in_ready is also dropped by load_use_stall. That flag looks at in_valid,
// so decode must keep presenting the op unchanged while the stall is high.
module alu_src_pipe #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_src_sel,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  input  logic [DATA_W-1:0]  reg1_rdata,
  input  logic [DATA_W-1:0]  reg2_rdata,
  input  logic [DATA_W-1:0]  imm,
  input  logic [DATA_W-1:0]  curr_pc,
  input  logic               ex_we,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0]  ex_data,
  input  logic               ex_is_load,
  input  logic               mem_we,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]  mem_data,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               load_use_stall,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  alu_src1,
  output logic [DATA_W-1:0]  alu_src2,
  output logic [DATA_W-1:0]  store_data
);

  localparam logic [1:0] SEL_REG     = 2'd0;
  localparam logic [1:0] SEL_IMM     = 2'd1;
  localparam logic [1:0] SEL_FOUR_PC = 2'd2;
  localparam logic [1:0] SEL_IMM_PC  = 2'd3;

  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;
  logic [DATA_W-1:0] nxt_src1;
  logic [DATA_W-1:0] nxt_src2;
  logic              uses_rs1;
  logic              capture;

`ifndef ALU_SRC_FWD_WB_EN
  // WB results are not forwarded in this build; the regfile already returns them.
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_data};
`endif

  // Forward rs1: later assignments override earlier ones, so EX wins over MEM wins over WB.
  always_comb begin
    fwd1 = reg1_rdata;
    if (rs1_addr != '0) begin
`ifdef ALU_SRC_FWD_WB_EN
      if (wb_we && (wb_rd == rs1_addr)) fwd1 = wb_data;
`endif
      if (mem_we && (mem_rd == rs1_addr)) fwd1 = mem_data;
      if (ex_we && (ex_rd == rs1_addr)) fwd1 = ex_data;
    end
  end

  // Forward rs2 with the same priority order as rs1.
  always_comb begin
    fwd2 = reg2_rdata;
    if (rs2_addr != '0) begin
`ifdef ALU_SRC_FWD_WB_EN
      if (wb_we && (wb_rd == rs2_addr)) fwd2 = wb_data;
`endif
      if (mem_we && (mem_rd == rs2_addr)) fwd2 = mem_data;
      if (ex_we && (ex_rd == rs2_addr)) fwd2 = ex_data;
    end
  end

  // Operand select; PC and constant 4 pass through untouched.
  always_comb begin
    nxt_src1 = fwd1;
    nxt_src2 = fwd2;
    unique case (alu_src_sel)
      SEL_REG: begin
        nxt_src1 = fwd1;
        nxt_src2 = fwd2;
      end
      SEL_IMM: begin
        nxt_src1 = fwd1;
        nxt_src2 = imm;
      end
      SEL_FOUR_PC: begin
        nxt_src1 = DATA_W'(4);
        nxt_src2 = curr_pc;
      end
      SEL_IMM_PC: begin
        nxt_src1 = imm;
        nxt_src2 = curr_pc;
      end
      default: begin
        nxt_src1 = fwd1;
        nxt_src2 = fwd2;
      end
    endcase
  end

  // Load-use hazard: the EX load result cannot be forwarded yet.
  // rs2 is always checked because store_data is always forwarded from it.
  always_comb begin
    uses_rs1       = (alu_src_sel == SEL_REG) || (alu_src_sel == SEL_IMM);
    load_use_stall = in_valid && ex_we && ex_is_load && (ex_rd != '0) &&
                     (((ex_rd == rs1_addr) && uses_rs1) || (ex_rd == rs2_addr));
  end

  assign in_ready = (!out_valid || out_ready) && !load_use_stall && !flush;
  assign capture  = in_valid && in_ready;

  // One-entry output register.
  // Flush only clears valid: the data registers keep their value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      alu_src1   <= '0;
      alu_src2   <= '0;
      store_data <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      alu_src1   <= nxt_src1;
      alu_src2   <= nxt_src2;
      store_data <= fwd2;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_src_pipe.sv
// tb_alu_src_pipe: directed and randomized bench for alu_src_pipe.
// The reference model describes the stage as a pending-op queue.
// Operand values come from the forwarding and selection rules applied to the current inputs.
module tb_alu_src_pipe;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    alu_src_sel;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [DW-1:0] reg1_rdata;
  logic [DW-1:0] reg2_rdata;
  logic [DW-1:0] imm;
  logic [DW-1:0] curr_pc;
  logic          ex_we;
  logic [AW-1:0] ex_rd;
  logic [DW-1:0] ex_data;
  logic          ex_is_load;
  logic          mem_we;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          wb_we;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          load_use_stall;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] alu_src1;
  logic [DW-1:0] alu_src2;
  logic [DW-1:0] store_data;

  alu_src_pipe #(.DATA_W(DW), .RADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_src_sel(alu_src_sel), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .reg1_rdata(reg1_rdata), .reg2_rdata(reg2_rdata), .imm(imm), .curr_pc(curr_pc),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_data(ex_data), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .load_use_stall(load_use_stall), .out_valid(out_valid), .out_ready(out_ready),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .store_data(store_data)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: pending op (at most one) plus last loaded operand values.
  logic [3*DW-1:0] exp_q[$];
  logic [DW-1:0]   m_src1, m_src2, m_store;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value the op would see for a source register, following the forwarding rules.
  function automatic logic [DW-1:0] ref_fwd(input logic [AW-1:0] rs, input logic [DW-1:0] rf);
    logic [DW-1:0] v;
    v = rf;
    if (rs == 0) return rf;
    if (ex_we && ex_rd == rs) return ex_data;
    if (mem_we && mem_rd == rs) return mem_data;
`ifdef ALU_SRC_FWD_WB_EN
    if (wb_we && wb_rd == rs) return wb_data;
`endif
    return v;
  endfunction

  function automatic logic ref_stall();
    logic hit1, hit2;
    hit1 = (ex_rd == rs1_addr) && (alu_src_sel <= 2'd1);
    hit2 = (ex_rd == rs2_addr);
    return in_valid && ex_we && ex_is_load && (ex_rd != 0) && (hit1 || hit2);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_src1 = '0; m_src2 = '0; m_store = '0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".out_valid"}, DW'(out_valid), DW'(exp_q.size() != 0));
    chk({tag, ".src1"}, alu_src1, m_src1);
    chk({tag, ".src2"}, alu_src2, m_src2);
    chk({tag, ".store"}, store_data, m_store);
  endtask

  // One clock: check handshake outputs, advance the model, check registers.
  // Called just after a falling edge with inputs already applied.
  task automatic step(input string tag);
    logic stall, rdy, acc;
    logic [DW-1:0] f1, f2, s1, s2;
    #1;
    stall = ref_stall();
    rdy   = (exp_q.size() == 0 || out_ready) && !stall && !flush;
    acc   = in_valid && rdy;
    chk({tag, ".stall"}, DW'(load_use_stall), DW'(stall));
    chk({tag, ".in_ready"}, DW'(in_ready), DW'(rdy));
    f1 = ref_fwd(rs1_addr, reg1_rdata);
    f2 = ref_fwd(rs2_addr, reg2_rdata);
    case (alu_src_sel)
      2'd0: begin s1 = f1; s2 = f2; end
      2'd1: begin s1 = f1; s2 = imm; end
      2'd2: begin s1 = 32'd4; s2 = curr_pc; end
      default: begin s1 = imm; s2 = curr_pc; end
    endcase
    @(posedge clk);
    if (flush) exp_q.delete();
    else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({s1, s2, f2});
        {m_src1, m_src2, m_store} = {s1, s2, f2};
      end
    end
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  // Driver helpers
  task automatic drive_idle();
    flush = 0; in_valid = 0; alu_src_sel = 0; rs1_addr = 0; rs2_addr = 0;
    reg1_rdata = 0; reg2_rdata = 0; imm = 0; curr_pc = 0;
    ex_we = 0; ex_rd = 0; ex_data = 0; ex_is_load = 0;
    mem_we = 0; mem_rd = 0; mem_data = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    out_ready = 1;
  endtask

  task automatic drive_op(input logic [1:0] sel, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                          input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                          input logic [DW-1:0] im, input logic [DW-1:0] pc);
    in_valid = 1; alu_src_sel = sel; rs1_addr = r1; rs2_addr = r2;
    reg1_rdata = d1; reg2_rdata = d2; imm = im; curr_pc = pc;
  endtask

  task automatic drive_random();
    flush      = ($urandom_range(0, 15) == 0);
    in_valid   = ($urandom_range(0, 3) != 0);
    out_ready  = ($urandom_range(0, 3) != 0);
    alu_src_sel = 2'($urandom_range(0, 3));
    rs1_addr   = AW'($urandom_range(0, 7));
    rs2_addr   = AW'($urandom_range(0, 7));
    reg1_rdata = $urandom; reg2_rdata = $urandom; imm = $urandom; curr_pc = $urandom;
    ex_we      = $urandom_range(0, 1); ex_rd = AW'($urandom_range(0, 7)); ex_data = $urandom;
    ex_is_load = ($urandom_range(0, 3) == 0);
    mem_we     = $urandom_range(0, 1); mem_rd = AW'($urandom_range(0, 7)); mem_data = $urandom;
    wb_we      = $urandom_range(0, 1); wb_rd = AW'($urandom_range(0, 7)); wb_data = $urandom;
  endtask

  logic [DW-1:0] held1, held2, held3;

  initial begin
    drive_idle();
    model_reset();
    rst_n = 0;
    #2;
    check_regs("reset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Operand select with forwarding from EX; IMM select
    drive_op(2'd1, 5'd5, 5'd0, 32'h10, 32'h0, 32'hFFFF_FFFC, 32'h0);
    ex_we = 1; ex_rd = 5'd5; ex_data = 32'h99;
    step("imm_fwd_ex");
    chk("imm_fwd_ex.src1_const", alu_src1, 32'h99);
    chk("imm_fwd_ex.src2_const", alu_src2, 32'hFFFF_FFFC);

    // EX beats MEM on rs2
    drive_idle();
    drive_op(2'd0, 5'd0, 5'd7, 32'h1, 32'h2, 32'h0, 32'h0);
    ex_we = 1; ex_rd = 5'd7; ex_data = 32'hA;
    mem_we = 1; mem_rd = 5'd7; mem_data = 32'hB;
    step("ex_over_mem");
    chk("ex_over_mem.src2_const", alu_src2, 32'hA);
    chk("ex_over_mem.store_const", store_data, 32'hA);

    // x0 is never forwarded
    drive_idle();
    drive_op(2'd0, 5'd0, 5'd0, 32'h55, 32'h66, 32'h0, 32'h0);
    ex_we = 1; ex_rd = 5'd0; ex_data = 32'hDEAD;
    step("x0_nofwd");
    chk("x0_nofwd.src1_const", alu_src1, 32'h55);

    // Load-use stall for one cycle, then capture with the MEM value
    drive_idle();
    drive_op(2'd0, 5'd3, 5'd1, 32'h30, 32'h31, 32'h0, 32'h0);
    ex_we = 1; ex_rd = 5'd3; ex_is_load = 1; ex_data = 32'hBAD;
    step("load_use");
    chk("load_use.stall_const", DW'(load_use_stall), 32'd1);
    ex_we = 0; ex_is_load = 0; mem_we = 1; mem_rd = 5'd3; mem_data = 32'h77;
    step("load_use_rel");
    chk("load_use_rel.src1_const", alu_src1, 32'h77);

    // PC-relative selects
    drive_idle();
    drive_op(2'd2, 5'd1, 5'd2, 32'h1, 32'h2, 32'h20, 32'h100);
    step("four_pc");
    chk("four_pc.src1_const", alu_src1, 32'd4);
    chk("four_pc.src2_const", alu_src2, 32'h100);
    alu_src_sel = 2'd3;
    step("imm_pc");
    chk("imm_pc.src1_const", alu_src1, 32'h20);

    // Backpressure for three cycles while decode offers a different op
    out_ready = 0;
    held1 = alu_src1; held2 = alu_src2; held3 = store_data;
    drive_op(2'd0, 5'd4, 5'd6, 32'hAAAA, 32'hBBBB, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step("backpressure");
      chk("backpressure.hold1", alu_src1, held1);
      chk("backpressure.hold2", alu_src2, held2);
      chk("backpressure.hold3", store_data, held3);
    end

    // Flush drops the buffered op and the offered op
    flush = 1;
    step("flush");
    chk("flush.out_valid_const", DW'(out_valid), 32'd0);
    flush = 0;

    // Back-to-back ops at full throughput
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive_op(2'd0, 5'd1, 5'd2, 32'h100 + i, 32'h200 + i, 32'h0, 32'h0);
      step("b2b");
      chk("b2b.src1_const", alu_src1, 32'h100 + i);
    end

    // Reset in the middle of a held op
    out_ready = 0;
    step("pre_reset");
    #2 rst_n = 0;
    #1;
    model_reset();
    check_regs("async_reset");
    @(negedge clk);
    rst_n = 1;
    drive_idle();
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive_random();
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Whole-run time limit
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
